// File: rtl/au_pkg.sv
// au_pkg: shared states, tap order and address helpers for the biquad cascade sequencer
package au_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, MAC, SKIP, UPD, OUT} state_e;
  typedef enum logic [2:0] {TapB0, TapB1, TapB2, TapA1, TapA2} tap_e;
  localparam int NumTaps = 5;
  localparam int TapStride = 8;
  function automatic int coef_aw(input int n);
    return $clog2(n) + 3;
  endfunction
endpackage

// File: rtl/au_biquad_mac.sv
// au_biquad_mac: shared multiply-accumulate with Q-format rescale and output saturation
module au_biquad_mac #(
  parameter int SampleWidth = 16,
  parameter int CoeffWidth = 16,
  parameter int CoeffFrac = 14,
  parameter int AccWidth = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr,
  input  logic                   acc_en,
  input  logic                   sub,
  input  logic [SampleWidth-1:0] operand,
  input  logic [CoeffWidth-1:0]  coef,
  output logic [SampleWidth-1:0] y,
  output logic                   clipped
);
  logic signed [SampleWidth+CoeffWidth-1:0] prod;
  logic signed [AccWidth-1:0] acc, term, sh;
  logic [AccWidth-SampleWidth:0] top;
  always_comb begin
    prod = $signed(operand) * $signed(coef);
    term = AccWidth'(prod);
    sh = acc >>> CoeffFrac;
    top = sh[AccWidth-1:SampleWidth-1];
    // value fits only when every bit above the sample's sign bit matches it
    clipped = ~(&top | ~|top);
    y = clipped ? {sh[AccWidth-1], {(SampleWidth-1){~sh[AccWidth-1]}}} : sh[SampleWidth-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) acc <= '0;
    else if (acc_en) acc <= sub ? acc - term : acc + term;
  end
endmodule

// File: rtl/au_cascade_sequencer.sv
// au_cascade_sequencer: runs each sample through NumStages DF-I biquads on one shared MAC
module au_cascade_sequencer
  import au_pkg::*;
#(
  parameter int NumStages = 4,
  parameter int SampleWidth = 16,
  parameter int CoeffWidth = 16,
  parameter int CoeffFrac = 14,
  parameter int AccWidth = 40
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [NumStages-1:0]             bypass_i,
  input  logic                             clear_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [SampleWidth-1:0]           in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [SampleWidth-1:0]           out_data_o,
  output logic                             coef_req_o,
  output logic [coef_aw(NumStages)-1:0]    coef_addr_o,
  input  logic [CoeffWidth-1:0]            coef_rdata_i,
  output logic                             busy_o,
  output logic [15:0]                      sat_cnt_o
);
  localparam int AddrWidth = coef_aw(NumStages);
  localparam int StW = NumStages > 1 ? $clog2(NumStages) : 1;
  state_e state, nstate, adv;
  tap_e tap;
  logic [StW-1:0] st, nst, sidx;
  logic last, accept, clear_pending, clr_hist, out_v, clipped;
  logic [SampleWidth-1:0] x_cur, operand, y;
  logic [SampleWidth-1:0] x1 [NumStages];
  logic [SampleWidth-1:0] x2 [NumStages];
  logic [SampleWidth-1:0] y1 [NumStages];
  logic [SampleWidth-1:0] y2 [NumStages];
  au_biquad_mac #(
    .SampleWidth(SampleWidth),
    .CoeffWidth(CoeffWidth),
    .CoeffFrac(CoeffFrac),
    .AccWidth(AccWidth)
  ) u_mac (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr(state == ADDR),
    .acc_en(state == MAC),
    .sub(tap >= TapA1),
    .operand(operand),
    .coef(coef_rdata_i),
    .y(y),
    .clipped(clipped)
  );
  always_comb begin
    nst = st + 1'b1;
    last = st == StW'(NumStages - 1);
    // bypass is looked up for whichever stage is about to start
    sidx = state == IDLE ? '0 : nst;
    adv = bypass_i[sidx] ? SKIP : ADDR;
    in_ready_o = ~rst_i & enable_i & (state == IDLE) & ~clear_pending;
    accept = in_valid_i & in_ready_o;
    clr_hist = (state == IDLE) & (clear_i | clear_pending);
    busy_o = state != IDLE;
    out_valid_o = out_v;
    out_data_o = x_cur;
    coef_req_o = (state == ADDR) | ((state == MAC) & (tap != TapA2));
    coef_addr_o = coef_req_o ? AddrWidth'(int'(st) * TapStride + (state == MAC ? int'(tap) + 1 : 0)) : '0;
    operand = tap == TapB0 ? x_cur : tap == TapB1 ? x1[st] : tap == TapB2 ? x2[st] : tap == TapA1 ? y1[st] : y2[st];
    nstate = state;
    case (state)
      IDLE: nstate = accept ? adv : IDLE;
      ADDR: nstate = MAC;
      MAC: nstate = tap == tap_e'(NumTaps - 1) ? UPD : MAC;
      UPD, SKIP: nstate = last ? OUT : adv;
      OUT: nstate = out_v & out_ready_i ? IDLE : OUT;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tap <= TapB0;
      st <= '0;
      x_cur <= '0;
      out_v <= 1'b0;
      clear_pending <= 1'b0;
      sat_cnt_o <= '0;
      for (int i = 0; i < NumStages; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      state <= nstate;
      // valid rises one cycle into OUT so the result register has settled
      out_v <= (state == OUT) & ~(out_v & out_ready_i);
      clear_pending <= (state != IDLE) & (clear_pending | clear_i);
      tap <= (state == MAC && tap != TapA2) ? tap_e'(tap + 1'b1) : TapB0;
      if (accept) begin
        x_cur <= in_data_i;
        st <= '0;
      end
      if (state == UPD) begin
        x_cur <= y;
        x1[st] <= x_cur;
        x2[st] <= x1[st];
        y1[st] <= y;
        y2[st] <= y1[st];
        if (clipped && sat_cnt_o != '1) sat_cnt_o <= sat_cnt_o + 1'b1;
      end
      if ((state == UPD || state == SKIP) && !last) st <= nst;
      if (clr_hist) begin
        for (int i = 0; i < NumStages; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_au_cascade_sequencer.sv
// tb_au_cascade_sequencer: directed vectors with hand-computed results for the biquad sequencer
module tb_au_cascade_sequencer;
  logic clk = 0, rst = 1, enable = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [3:0] bypass = 4'b1111;
  logic [15:0] in_data = 0, coef_rdata = 0;
  logic in_ready, out_valid, coef_req, busy;
  logic [15:0] out_data, sat_cnt;
  logic [4:0] coef_addr;
  logic [15:0] mem [32];
  int n_cmp = 0, n_bad = 0;
  int addr_q[$];
  always #5 clk = ~clk;
  au_cascade_sequencer dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .bypass_i(bypass),
    .clear_i(clear),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o(out_data),
    .coef_req_o(coef_req),
    .coef_addr_o(coef_addr),
    .coef_rdata_i(coef_rdata),
    .busy_o(busy),
    .sat_cnt_o(sat_cnt)
  );
  // coefficient memory with one cycle of read latency
  always @(posedge clk) if (coef_req) coef_rdata <= mem[coef_addr];
  always @(negedge clk) if (coef_req) addr_q.push_back(int'(coef_addr));
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input int x, output int lat, output int y);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_valid = 1;
    in_data = 16'(x);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 200);
    y = int'($signed(out_data));
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_clear();
    @(negedge clk) clear = 1;
    @(negedge clk) clear = 0;
  endtask
  task automatic zero_mem();
    for (int i = 0; i < 32; i++) mem[i] = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, y, cnt;
    zero_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_coef_req", coef_req, 0);
    chk("rst_coef_addr", coef_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(negedge clk) rst = 0;
    mem[0] = 16384;
    bypass = 4'b1110;
    send(1000, lat, y);
    chk("unity_y", y, 1000);
    chk("unity_lat", lat, 11);
    chk("unity_sat", sat_cnt, 0);
    mem[3] = 16'hE000;
    pulse_clear();
    send(1000, lat, y);
    chk("rec_y0", y, 1000);
    send(0, lat, y);
    chk("rec_y1", y, 500);
    send(0, lat, y);
    chk("rec_y2", y, 250);
    send(0, lat, y);
    chk("rec_hist", y, 125);
    mem[0] = 16'h7FFF;
    mem[3] = 0;
    send(30000, lat, y);
    chk("sat_pos_y", y, 32767);
    chk("sat_pos_cnt", sat_cnt, 1);
    send(-30000, lat, y);
    chk("sat_neg_y", y, -32768);
    chk("sat_neg_cnt", sat_cnt, 2);
    zero_mem();
    mem[0] = 16384;
    mem[8] = 16384;
    mem[16] = 16384;
    mem[24] = 16384;
    bypass = 4'b0000;
    addr_q.delete();
    send(-1234, lat, y);
    chk("casc_y", y, -1234);
    chk("casc_lat", lat, 29);
    chk("addr_count", addr_q.size(), 20);
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < 5; t++)
        chk("addr_seq", addr_q.size() > s * 5 + t ? addr_q[s * 5 + t] : -1, s * 8 + t);
    out_ready = 0;
    send(500, lat, y);
    chk("bp_y", y, 500);
    in_valid = 1;
    in_data = 16'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", int'($signed(out_data)), 500);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    zero_mem();
    mem[0] = 16384;
    mem[3] = 16'hE000;
    bypass = 4'b1110;
    pulse_clear();
    send(1000, lat, y);
    chk("clr_first_y", y, 1000);
    fork
      send(0, lat, y);
      begin
        repeat (4) @(posedge clk);
        #2 clear = 1;
        @(posedge clk);
        #2 clear = 0;
      end
    join
    chk("clr_cur_y", y, 500);
    chk("clr_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("clr_ready_back", in_ready, 1);
    send(1000, lat, y);
    chk("clr_restart_y", y, 1000);
    @(negedge clk);
    in_valid = 1;
    in_data = 16'd1000;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sat", sat_cnt, 0);
    rst = 0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid) cnt++;
    end
    chk("mid_no_out", cnt, 0);
    send(1000, lat, y);
    chk("mid_clean_y", y, 1000);
    chk("mid_clean_lat", lat, 11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
